// File: rtl/draw_character_jump_pkg.sv
// draw_character_jump_pkg: shared FSM state enum, default pixel widths and screen limits
package draw_character_jump_pkg;
  localparam int DEF_H_BITS = 10;
  localparam int DEF_V_BITS = 9;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2} state_e;
endpackage

// File: rtl/draw_character_jump_if.sv
// draw_character_jump_if: pixel/control inputs (i_en, i_frame_tick, i_jump, i_x, i_y) and character outputs (o_character, o_ypos, o_airborne, o_state); master drives inputs, slave is the generator
interface draw_character_jump_if import draw_character_jump_pkg::*; #(
  parameter int H_BITS = DEF_H_BITS,
  parameter int V_BITS = DEF_V_BITS
);
  logic i_en;
  logic i_frame_tick;
  logic i_jump;
  logic [H_BITS-1:0] i_x;
  logic [V_BITS-1:0] i_y;
  logic o_character;
  logic [V_BITS-1:0] o_ypos;
  logic o_airborne;
  logic [1:0] o_state;
  modport master (
    output i_en, i_frame_tick, i_jump, i_x, i_y,
    input  o_character, o_ypos, o_airborne, o_state
  );
  modport slave (
    input  i_en, i_frame_tick, i_jump, i_x, i_y,
    output o_character, o_ypos, o_airborne, o_state
  );
endinterface

// File: rtl/draw_character_jump_motion_fsm.sv
// character_motion_fsm: per-frame jump/gravity FSM holding ypos, velocity and pending jump; in i_clk, i_rst_n, i_en, i_frame_tick, i_jump; out o_ypos, o_state
module character_motion_fsm import draw_character_jump_pkg::*; #(
  parameter int Y_GROUND = 380,
  parameter int Y_TOP = 40,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY = 1,
  parameter int MAX_FALL = 12,
  parameter int V_BITS = DEF_V_BITS
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_frame_tick,
  input  logic i_jump,
  output logic [V_BITS-1:0] o_ypos,
  output state_e o_state
);
  localparam int W = V_BITS + 1;
  state_e state_q, state_d;
  logic [V_BITS-1:0] ypos_q, ypos_d, vel_q, vel_d;
  logic jump_pending_q, jump_pending_d;
  logic tick;
  logic [W-1:0] y_ext, v_ext, v_fall;
  assign tick = i_frame_tick & i_en;
  assign y_ext = W'(ypos_q);
  assign v_ext = W'(vel_q);
  assign v_fall = (v_ext + W'(GRAVITY) > W'(MAX_FALL)) ? W'(MAX_FALL) : v_ext + W'(GRAVITY);
  always_comb begin
    state_d = state_q;
    ypos_d = ypos_q;
    vel_d = vel_q;
    jump_pending_d = jump_pending_q | (i_en & i_jump & (state_q == IDLE));
    case (state_q)
      IDLE: if (tick && (jump_pending_q || i_jump)) begin
        state_d = RISE;
        vel_d = V_BITS'(JUMP_VEL);
        jump_pending_d = 1'b0;
      end
      // ceiling test is ypos <= vel + Y_TOP so the subtraction never underflows
      RISE: if (tick) begin
        if (y_ext <= v_ext + W'(Y_TOP)) begin
          ypos_d = V_BITS'(Y_TOP);
          vel_d = '0;
          state_d = FALL;
        end else begin
          ypos_d = V_BITS'(y_ext - v_ext);
          vel_d = (v_ext <= W'(GRAVITY)) ? '0 : V_BITS'(v_ext - W'(GRAVITY));
          state_d = (v_ext <= W'(GRAVITY)) ? FALL : RISE;
        end
      end
      FALL: if (tick) begin
        if (y_ext + v_fall >= W'(Y_GROUND)) begin
          ypos_d = V_BITS'(Y_GROUND);
          vel_d = '0;
          state_d = IDLE;
        end else begin
          ypos_d = V_BITS'(y_ext + v_fall);
          vel_d = V_BITS'(v_fall);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ypos_q <= V_BITS'(Y_GROUND);
      vel_q <= '0;
      jump_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ypos_q <= ypos_d;
      vel_q <= vel_d;
      jump_pending_q <= jump_pending_d;
    end
  end
  assign o_ypos = ypos_q;
  assign o_state = state_q;
endmodule

// File: rtl/draw_character_jump.sv
// draw_character_jump: jumping character region generator; in i_clk, i_rst_n and bus inputs (i_en, i_frame_tick, i_jump, i_x, i_y); out registered o_character plus o_ypos, o_airborne, o_state
module draw_character_jump import draw_character_jump_pkg::*; #(
  parameter int XPOS = 100,
  parameter int WIDTH = 40,
  parameter int HEIGHT = 60,
  parameter int Y_GROUND = 380,
  parameter int Y_TOP = 40,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY = 1,
  parameter int MAX_FALL = 12,
  parameter int H_BITS = DEF_H_BITS,
  parameter int V_BITS = DEF_V_BITS
) (
  input logic i_clk,
  input logic i_rst_n,
  draw_character_jump_if.slave bus
);
  localparam int HW = H_BITS + 1;
  localparam int VW = V_BITS + 1;
  if (Y_TOP >= Y_GROUND) begin : g_bad_top
    $error("Y_TOP must be above Y_GROUND");
  end
  if (Y_GROUND + HEIGHT >= 2 ** V_BITS) begin : g_bad_height
    $error("Y_GROUND+HEIGHT must fit in V_BITS");
  end
  if (XPOS + WIDTH >= 2 ** H_BITS) begin : g_bad_width
    $error("XPOS+WIDTH must fit in H_BITS");
  end
  state_e state;
  logic [V_BITS-1:0] ypos;
  logic character_q, character_d;
  character_motion_fsm #(
    .Y_GROUND(Y_GROUND), .Y_TOP(Y_TOP), .JUMP_VEL(JUMP_VEL),
    .GRAVITY(GRAVITY), .MAX_FALL(MAX_FALL), .V_BITS(V_BITS)
  ) u_motion (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_en(bus.i_en),
    .i_frame_tick(bus.i_frame_tick),
    .i_jump(bus.i_jump),
    .o_ypos(ypos),
    .o_state(state)
  );
  always_comb
    character_d = bus.i_en
      && (HW'(bus.i_x) > HW'(XPOS)) && (HW'(bus.i_x) < HW'(XPOS) + HW'(WIDTH))
      && (VW'(bus.i_y) > VW'(ypos)) && (VW'(bus.i_y) < VW'(ypos) + VW'(HEIGHT));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) character_q <= 1'b0;
    else character_q <= character_d;
  end
  assign bus.o_character = character_q;
  assign bus.o_ypos = ypos;
  assign bus.o_airborne = (state == RISE) || (state == FALL);
  assign bus.o_state = state;
endmodule

// File: tb/tb_draw_character_jump.sv
// tb_draw_character_jump: randomized and directed checks of two generators (Y_TOP 40 and 340) against a tick-level physics model
module tb_draw_character_jump;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, tick = 1'b0, jump = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  int checks = 0, errors = 0;
  int m_y[2], m_v[2], m_st[2];
  bit m_pend[2], m_char[2];
  int ytop[2] = '{40, 340};
  always #5 clk = ~clk;
  draw_character_jump_if #(.H_BITS(10), .V_BITS(9)) bus1 ();
  draw_character_jump_if #(.H_BITS(10), .V_BITS(9)) bus2 ();
  assign bus1.i_en = en;
  assign bus1.i_frame_tick = tick;
  assign bus1.i_jump = jump;
  assign bus1.i_x = x;
  assign bus1.i_y = y;
  assign bus2.i_en = en;
  assign bus2.i_frame_tick = tick;
  assign bus2.i_jump = jump;
  assign bus2.i_x = x;
  assign bus2.i_y = y;
  draw_character_jump u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  draw_character_jump #(.Y_TOP(340)) u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));
  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_y[k] = 380; m_v[k] = 0; m_st[k] = 0; m_pend[k] = 0; m_char[k] = 0;
    end
  endtask
  // physics model: 0 grounded, 1 rising, 2 falling; advanced once per clock
  task automatic cycle;
    for (int k = 0; k < 2; k++) begin
      m_char[k] = en && x > 100 && x < 140 && int'(y) > m_y[k] && int'(y) < m_y[k] + 60;
      if (en && jump && m_st[k] == 0) m_pend[k] = 1;
      if (en && tick) begin
        if (m_st[k] == 0) begin
          if (m_pend[k]) begin m_v[k] = 12; m_st[k] = 1; m_pend[k] = 0; end
        end else if (m_st[k] == 1) begin
          if (m_y[k] - m_v[k] <= ytop[k]) begin
            m_y[k] = ytop[k]; m_v[k] = 0; m_st[k] = 2;
          end else begin
            m_y[k] -= m_v[k];
            m_v[k] -= 1;
            if (m_v[k] <= 0) begin m_v[k] = 0; m_st[k] = 2; end
          end
        end else begin
          int nv;
          nv = (m_v[k] + 1 > 12) ? 12 : m_v[k] + 1;
          if (m_y[k] + nv >= 380) begin m_y[k] = 380; m_v[k] = 0; m_st[k] = 0; end
          else begin m_y[k] += nv; m_v[k] = nv; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic tick_once;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask
  task automatic test_reset;
    checks += 8;
    if (bus1.o_ypos !== 9'd380) begin errors++; $display("FAIL reset_ypos1 got %0d want 380", bus1.o_ypos); end
    if (bus2.o_ypos !== 9'd380) begin errors++; $display("FAIL reset_ypos2 got %0d want 380", bus2.o_ypos); end
    if (bus1.o_state !== 2'd0) begin errors++; $display("FAIL reset_state1 got %0d want 0", bus1.o_state); end
    if (bus2.o_state !== 2'd0) begin errors++; $display("FAIL reset_state2 got %0d want 0", bus2.o_state); end
    if (bus1.o_character !== 1'b0) begin errors++; $display("FAIL reset_char1 got %0b want 0", bus1.o_character); end
    if (bus2.o_character !== 1'b0) begin errors++; $display("FAIL reset_char2 got %0b want 0", bus2.o_character); end
    if (bus1.o_airborne !== 1'b0) begin errors++; $display("FAIL reset_air1 got %0b want 0", bus1.o_airborne); end
    if (bus2.o_airborne !== 1'b0) begin errors++; $display("FAIL reset_air2 got %0b want 0", bus2.o_airborne); end
  endtask
  task automatic test_draw;
    int px[6] = '{101, 139, 100, 140, 101, 101};
    int py[6] = '{381, 439, 381, 400, 380, 440};
    bit pe[6] = '{1, 1, 0, 0, 0, 0};
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = 10'(px[i]);
      y = 9'(py[i]);
      cycle();
      checks++;
      if (bus1.o_character !== pe[i]) begin
        errors++;
        $display("FAIL draw(%0d,%0d) got %0b want %0b", px[i], py[i], bus1.o_character, pe[i]);
      end
    end
  endtask
  task automatic test_jump;
    int ey, es;
    ey = 380;
    jump = 1'b1;
    cycle();
    jump = 1'b0;
    cycle();
    for (int t = 1; t <= 25; t++) begin
      tick_once();
      if (t >= 2 && t <= 13) ey -= 14 - t;
      if (t >= 14) ey += t - 13;
      es = t < 13 ? 1 : t < 25 ? 2 : 0;
      checks += 3;
      if (bus1.o_ypos !== 9'(ey)) begin errors++; $display("FAIL jump_ypos tick%0d got %0d want %0d", t, bus1.o_ypos, ey); end
      if (bus1.o_state !== 2'(es)) begin errors++; $display("FAIL jump_state tick%0d got %0d want %0d", t, bus1.o_state, es); end
      if (bus1.o_airborne !== (es != 0)) begin errors++; $display("FAIL jump_air tick%0d got %0b want %0b", t, bus1.o_airborne, es != 0); end
    end
  endtask
  task automatic test_ceiling;
    int ey[5] = '{380, 368, 357, 347, 340};
    int es[5] = '{1, 1, 1, 1, 2};
    jump = 1'b1;
    cycle();
    jump = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick_once();
      checks += 2;
      if (bus2.o_ypos !== 9'(ey[t])) begin errors++; $display("FAIL ceil_ypos tick%0d got %0d want %0d", t + 1, bus2.o_ypos, ey[t]); end
      if (bus2.o_state !== 2'(es[t])) begin errors++; $display("FAIL ceil_state tick%0d got %0d want %0d", t + 1, bus2.o_state, es[t]); end
    end
    repeat (20) tick_once();
    checks += 2;
    if (bus1.o_state !== 2'd0) begin errors++; $display("FAIL ceil_land1 got %0d want 0", bus1.o_state); end
    if (bus2.o_state !== 2'd0) begin errors++; $display("FAIL ceil_land2 got %0d want 0", bus2.o_state); end
  endtask
  task automatic test_hold;
    jump = 1'b1;
    cycle();
    for (int t = 1; t <= 25; t++) begin
      if (t == 25) jump = 1'b0;
      tick_once();
      if (t == 13 || t == 14) begin
        checks += 2;
        if (bus1.o_state !== 2'd2) begin errors++; $display("FAIL hold_state tick%0d got %0d want 2", t, bus1.o_state); end
        if (bus1.o_ypos !== (t == 13 ? 9'd302 : 9'd303)) begin errors++; $display("FAIL hold_ypos tick%0d got %0d", t, bus1.o_ypos); end
      end
    end
    checks += 2;
    if (bus1.o_state !== 2'd0) begin errors++; $display("FAIL hold_land got %0d want 0", bus1.o_state); end
    if (bus1.o_ypos !== 9'd380) begin errors++; $display("FAIL hold_land_y got %0d want 380", bus1.o_ypos); end
    jump = 1'b1;
    tick = 1'b1;
    cycle();
    jump = 1'b0;
    tick = 1'b0;
    cycle();
    checks += 2;
    if (bus1.o_state !== 2'd1) begin errors++; $display("FAIL same_tick_state got %0d want 1", bus1.o_state); end
    if (bus1.o_ypos !== 9'd380) begin errors++; $display("FAIL same_tick_ypos got %0d want 380", bus1.o_ypos); end
    repeat (24) tick_once();
    checks++;
    if (bus1.o_state !== 2'd0) begin errors++; $display("FAIL same_tick_land got %0d want 0", bus1.o_state); end
  endtask
  task automatic test_enable;
    x = 10'd120;
    y = 9'd400;
    jump = 1'b1;
    cycle();
    jump = 1'b0;
    tick_once();
    tick_once();
    checks += 2;
    if (bus1.o_ypos !== 9'd368) begin errors++; $display("FAIL en_pre_ypos got %0d want 368", bus1.o_ypos); end
    if (bus1.o_character !== 1'b1) begin errors++; $display("FAIL en_pre_char got %0b want 1", bus1.o_character); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_once();
      checks += 3;
      if (bus1.o_ypos !== 9'd368) begin errors++; $display("FAIL en_frozen_ypos got %0d want 368", bus1.o_ypos); end
      if (bus1.o_state !== 2'd1) begin errors++; $display("FAIL en_frozen_state got %0d want 1", bus1.o_state); end
      if (bus1.o_character !== 1'b0) begin errors++; $display("FAIL en_off_char got %0b want 0", bus1.o_character); end
    end
    en = 1'b1;
    tick_once();
    checks += 3;
    if (bus1.o_ypos !== 9'd357) begin errors++; $display("FAIL en_resume_ypos got %0d want 357", bus1.o_ypos); end
    if (bus1.o_state !== 2'd1) begin errors++; $display("FAIL en_resume_state got %0d want 1", bus1.o_state); end
    if (bus1.o_character !== 1'b1) begin errors++; $display("FAIL en_resume_char got %0b want 1", bus1.o_character); end
    repeat (22) tick_once();
    checks++;
    if (bus1.o_state !== 2'd0) begin errors++; $display("FAIL en_land got %0d want 0", bus1.o_state); end
  endtask
  task automatic test_async_reset;
    jump = 1'b1;
    cycle();
    jump = 1'b0;
    repeat (13) tick_once();
    checks += 2;
    if (bus1.o_state !== 2'd2) begin errors++; $display("FAIL arst_pre1 got %0d want 2", bus1.o_state); end
    if (bus2.o_state !== 2'd2) begin errors++; $display("FAIL arst_pre2 got %0d want 2", bus2.o_state); end
    #3 rst_n = 1'b0;
    #1;
    checks += 8;
    if (bus1.o_ypos !== 9'd380) begin errors++; $display("FAIL arst_ypos1 got %0d want 380", bus1.o_ypos); end
    if (bus2.o_ypos !== 9'd380) begin errors++; $display("FAIL arst_ypos2 got %0d want 380", bus2.o_ypos); end
    if (bus1.o_state !== 2'd0) begin errors++; $display("FAIL arst_state1 got %0d want 0", bus1.o_state); end
    if (bus2.o_state !== 2'd0) begin errors++; $display("FAIL arst_state2 got %0d want 0", bus2.o_state); end
    if (bus1.o_airborne !== 1'b0) begin errors++; $display("FAIL arst_air1 got %0b want 0", bus1.o_airborne); end
    if (bus2.o_airborne !== 1'b0) begin errors++; $display("FAIL arst_air2 got %0b want 0", bus2.o_airborne); end
    if (bus1.o_character !== 1'b0) begin errors++; $display("FAIL arst_char1 got %0b want 0", bus1.o_character); end
    if (bus2.o_character !== 1'b0) begin errors++; $display("FAIL arst_char2 got %0b want 0", bus2.o_character); end
    #2 rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_random;
    logic [8:0] gy;
    logic [1:0] gs;
    logic gc, ga;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      tick = ($urandom_range(0, 3) == 0);
      jump = ($urandom_range(0, 15) == 0);
      x = 10'($urandom_range(95, 145));
      y = 9'($urandom_range(300, 470));
      cycle();
      for (int k = 0; k < 2; k++) begin
        gy = k == 0 ? bus1.o_ypos : bus2.o_ypos;
        gs = k == 0 ? bus1.o_state : bus2.o_state;
        gc = k == 0 ? bus1.o_character : bus2.o_character;
        ga = k == 0 ? bus1.o_airborne : bus2.o_airborne;
        checks += 4;
        if (gy !== 9'(m_y[k])) begin errors++; $display("FAIL rnd_ypos dut%0d cyc%0d got %0d want %0d", k + 1, i, gy, m_y[k]); end
        if (gs !== 2'(m_st[k])) begin errors++; $display("FAIL rnd_state dut%0d cyc%0d got %0d want %0d", k + 1, i, gs, m_st[k]); end
        if (gc !== m_char[k]) begin errors++; $display("FAIL rnd_char dut%0d cyc%0d got %0b want %0b", k + 1, i, gc, m_char[k]); end
        if (ga !== (m_st[k] != 0)) begin errors++; $display("FAIL rnd_air dut%0d cyc%0d got %0b want %0b", k + 1, i, ga, m_st[k] != 0); end
      end
    end
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_draw();
    test_jump();
    test_ceiling();
    test_hold();
    test_enable();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_character_jump.md
Name: draw_character_jump

Overview:
- Parametrised successor to the static character region generator.
- Holds the character's vertical position in registers and runs a per-frame jump/gravity state machine.
- Produces a registered pixel-in-character flag for the VGA colour mux.
- Sits between the VGA timing generator (pixel x/y, frame tick) and the colour output logic; one instance per on-screen character.

Parameters:
- XPOS, 100, fixed left edge of character (pixels)
- WIDTH, 40, character width (pixels)
- HEIGHT, 60, character height (pixels)
- Y_GROUND, 380, resting top-edge y (screen y grows downward)
- Y_TOP, 40, highest allowed top-edge y (ceiling)
- JUMP_VEL, 12, initial upward velocity (pixels/frame)
- GRAVITY, 1, velocity change per frame
- MAX_FALL, 12, terminal downward velocity
- H_BITS, 10, pixel x width
- V_BITS, 9, pixel y width

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_en  in  1  enable; gates drawing and motion
- i_frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- i_jump  in  1  jump request (level or pulse)
- i_x  in  H_BITS  current pixel x
- i_y  in  V_BITS  current pixel y
- o_character  out  1  registered: current pixel lies inside the character
- o_ypos  out  V_BITS  current top-edge y
- o_airborne  out  1  high in RISE or FALL
- o_state  out  2  FSM state encoding

Behaviour:
- Clock and reset:
  - Single clock i_clk; reset is asynchronous and active-low on i_rst_n.
  - Reset values: o_ypos=Y_GROUND, velocity=0, state=IDLE, jump_pending=0, o_character=0, o_airborne=0.
  - Reset asserted mid-jump returns immediately to these values.
- States: IDLE=0 (grounded), RISE=1, FALL=2; encoding 3 is unused and recovers to IDLE on the next cycle.
- Jump request capture:
  - jump_pending is set on any cycle with i_jump=1, i_en=1 and state=IDLE.
  - Requests while airborne are dropped, never queued.
- All motion updates occur only on cycles with i_frame_tick=1 and i_en=1. Otherwise ypos, velocity and state hold.
- IDLE on tick:
  - If jump_pending, or i_jump=1 on the tick cycle itself: velocity<=JUMP_VEL, state<=RISE, clear pending. ypos does not change this tick.
- RISE on tick:
  - If ypos-velocity <= Y_TOP: ypos<=Y_TOP, velocity<=0, state<=FALL.
  - Otherwise: ypos<=ypos-velocity, velocity<=velocity-GRAVITY. If the result is <=0, velocity<=0 and state<=FALL.
- FALL on tick:
  - v'=min(velocity+GRAVITY, MAX_FALL).
  - If ypos+v' >= Y_GROUND: ypos<=Y_GROUND, velocity<=0, state<=IDLE.
  - Otherwise: ypos<=ypos+v', velocity<=v'.
- Arithmetic widths:
  - Velocity is an unsigned magnitude of V_BITS bits; direction is implied by state.
  - Position sums and compares use V_BITS+1 bits, so they never wrap.
- Draw output:
  - o_character is registered with 1-cycle latency from i_x/i_y.
  - o_character = i_en & (i_x > XPOS) & (i_x < XPOS+WIDTH) & (i_y > ypos) & (i_y < ypos+HEIGHT).
  - Bounds are strict on all four edges.
  - Compares use H_BITS+1 / V_BITS+1 bits.
  - ypos changes only at a frame tick, so there is no mid-frame tearing.
- i_en=0: o_character is 0 the following cycle and motion freezes; state and position resume when i_en returns.
- Elaboration-time requirements: Y_TOP < Y_GROUND, Y_GROUND+HEIGHT < 2^V_BITS, XPOS+WIDTH < 2^H_BITS.

Decomposition:
- Shared package holds:
  - state enum (IDLE/RISE/FALL)
  - default width constants H_BITS/V_BITS
  - screen limits 640/480
- Sub-module character_motion_fsm holds the FSM, velocity, ypos and jump_pending; it outputs ypos and state.
- The top level adds the registered region comparator.

Test Plan:
- Reset, then scan pixels -> o_ypos=380; o_character=1 one cycle after (x=101,y=381) and after (139,439); 0 after (100,381), (140,400), (101,380), (101,440).
- Pulse i_jump in IDLE, then frame ticks:
  - tick 1 -> RISE, ypos=380.
  - ticks 2-13 -> ypos 368,357,...,302 (decrements 12..1); after tick 13 state=FALL.
  - ticks 14-25 -> ypos 303,305,...,380 (increments 1..12); after tick 25 state=IDLE, o_airborne=0.
- Override Y_TOP=340; jump -> rise ticks give 368,357,347, then ypos=340 with state=FALL and velocity 0.
- i_jump held during RISE and FALL -> no re-trigger. A jump asserted on the same cycle as a tick in IDLE -> RISE on that tick.
- i_en=0 for 5 ticks mid-RISE -> ypos and state frozen, o_character=0. Re-enable -> the sequence continues from the frozen values.
- Assert i_rst_n=0 asynchronously mid-FALL -> outputs return immediately to reset values without waiting for a clock edge.
